// File: rtl/snn_pkg.sv
// Shared definitions for the SNN image-load path.
//   IMG_BITS / IMG_BYTES : pixel bits and bytes in one frame
//   ADDR_W               : input-RAM address width
//   state_t              : image_load_ctrl FSM state encoding
package snn_pkg;

  localparam int IMG_BITS  = 784;
  localparam int IMG_BYTES = 98;
  localparam int ADDR_W    = 10;

  typedef enum logic [2:0] {
    LOAD_WAIT = 3'd0,
    LOAD_BITS = 3'd1,
    RUN       = 3'd2,
    TX        = 3'd3,
    TX_WAIT   = 3'd4
  } state_t;

endpackage

// File: rtl/image_load_ctrl_bit_unpacker.sv
// bit_unpacker: serialises one received byte into 8 single-bit writes, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data and restart the bit count
//   load_data  : byte to serialise
//   shift      : advance one bit (shift right, count +1)
//   bit_out    : current bit (shift register LSB)
//   last       : the bit being presented is the 8th of the byte
module bit_unpacker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  output logic       bit_out,
  output logic       last
);

  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= 3'd0;
    end else if (shift) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  assign bit_out = shift_reg[0];
  assign last    = (bit_cnt == 3'd7);

endmodule

// File: rtl/image_load_ctrl.sv
// image_load_ctrl: receives a frame of packed pixel bytes from the UART, unpacks
// it bit-by-bit into the SNN input RAM, starts the core, and returns the
// classified digit over the UART and on the LEDs.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_rdy, rx_data       : received byte strobe and data (pixels LSB first)
//   ram_addr/we/wdata     : input-RAM write port (core_addr passes through when idle)
//   core_addr             : RAM address requested by the SNN core
//   core_start, core_done : core handshake; core_digit valid with core_done
//   tx_start, tx_data, tx_rdy : UART transmit request / byte / idle
//   led                   : last classification result
//   busy                  : high whenever not waiting for a byte
//   frame_err             : sticky error (discarded byte or partial-frame timeout)
module image_load_ctrl #(
  parameter int IMG_BYTES = 98,
  parameter int TIMEOUT   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic       ram_wdata,
  input  logic [9:0] core_addr,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  output logic [7:0] led,
  output logic       busy,
  output logic       frame_err
);

  import snn_pkg::*;

  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES * 8 - 1);

  state_t             state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               tx_first;

  logic               unp_load;
  logic               unp_shift;
  logic               unp_bit;
  logic               unp_last;
  logic               frame_done;
  logic               idle_active;
  logic               timeout_hit;
  logic               err_set;
  logic               err_clr;

  assign unp_load    = (state == LOAD_WAIT) && rx_rdy;
  assign unp_shift   = (state == LOAD_BITS);
  assign frame_done  = unp_shift && unp_last && (wr_ptr == LAST_ADDR);

  // Idle timing only matters once a frame is partially loaded.
  assign idle_active = (state == LOAD_WAIT) && (wr_ptr != '0);
  assign timeout_hit = idle_active && !rx_rdy && (idle_cnt == IDLE_LAST);

  assign err_set     = timeout_hit || (rx_rdy && (state != LOAD_WAIT));
  assign err_clr     = rx_rdy && (state == LOAD_WAIT) && (wr_ptr == '0);

  bit_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (unp_load),
    .load_data (rx_data),
    .shift     (unp_shift),
    .bit_out   (unp_bit),
    .last      (unp_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_WAIT;
      core_start <= 1'b0;
      led        <= 8'h00;
      tx_data    <= 8'h00;
    end else begin
      core_start <= 1'b0;
      case (state)
        LOAD_WAIT: if (rx_rdy) state <= LOAD_BITS;
        LOAD_BITS: begin
          if (unp_last) begin
            if (frame_done) begin
              state      <= RUN;
              core_start <= 1'b1;
            end else begin
              state <= LOAD_WAIT;
            end
          end
        end
        RUN: begin
          if (core_done) begin
            state   <= TX;
            led     <= {4'h0, core_digit};
            tx_data <= {4'h0, core_digit};
          end
        end
        TX:      state <= TX_WAIT;
        // tx_rdy may still read high in the cycle right after the request.
        TX_WAIT: if (!tx_first && tx_rdy) state <= LOAD_WAIT;
        default: state <= LOAD_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_first <= 1'b0;
    else        tx_first <= (state == TX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (unp_shift) begin
      wr_ptr <= frame_done ? '0 : wr_ptr + 1'b1;
    end else if (timeout_hit) begin
      wr_ptr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!idle_active || rx_rdy || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       frame_err <= 1'b0;
    else if (err_set) frame_err <= 1'b1;
    else if (err_clr) frame_err <= 1'b0;
  end

  assign ram_we    = unp_shift;
  assign ram_addr  = unp_shift ? wr_ptr : core_addr;
  assign ram_wdata = unp_shift & unp_bit;
  assign tx_start  = (state == TX);
  assign busy      = (state != LOAD_WAIT);

endmodule

// File: tb/tb_image_load_ctrl.sv
module tb_image_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic       ram_wdata;
  logic [9:0] core_addr;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic [7:0] led;
  logic       busy;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // write monitor state
  logic [7:0] cur_byte;
  logic       mon_clr;
  int wr_cnt, addr_errs, data_errs, idle_errs, cs_cnt, ts_cnt, wr_at_cs;

  always #5 clk = ~clk;

  image_load_ctrl #(.IMG_BYTES(98), .TIMEOUT(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .core_addr  (core_addr),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .led        (led),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt    <= 0;
      addr_errs <= 0;
      data_errs <= 0;
      idle_errs <= 0;
      cs_cnt    <= 0;
      ts_cnt    <= 0;
      wr_at_cs  <= -1;
    end else begin
      if (ram_we) begin
        if (ram_addr != wr_cnt[9:0])           addr_errs <= addr_errs + 1;
        if (ram_wdata != cur_byte[wr_cnt[2:0]]) data_errs <= data_errs + 1;
        wr_cnt <= wr_cnt + 1;
      end else if (ram_wdata) begin
        idle_errs <= idle_errs + 1;
      end
      if (core_start) begin
        cs_cnt   <= cs_cnt + 1;
        wr_at_cs <= wr_cnt;
      end
      if (tx_start) ts_cnt <= ts_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b, input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      pulse_rx(b);
      wait_cycles(gap);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_rdy     = 1'b0;
    rx_data    = 8'h00;
    core_addr  = 10'h003;
    core_done  = 1'b0;
    core_digit = 4'h0;
    tx_rdy     = 1'b1;
    cur_byte   = 8'hA5;
    mon_clr    = 1'b1;
    wait_cycles(3);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_ram_addr", ram_addr, 10'h003);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_led", led, 8'h00);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_core_start", core_start, 1'b0);
    check_eq("rst_tx_start", tx_start, 1'b0);
    rst_n = 1'b1;
    wait_cycles(2);
    clear_mon();

    // Full frame of 0xA5, one byte every 50 cycles
    pulse_rx(8'hA5);
    check_eq("first_wr_we", ram_we, 1'b1);
    check_eq("first_wr_addr", ram_addr, 10'd0);
    check_eq("first_wr_bit", ram_wdata, 1'b1);
    wait_cycles(49);
    send_bytes(8'hA5, 97, 49);
    check_eq("a_wr_cnt", wr_cnt, 784);
    check_eq("a_addr_errs", addr_errs, 0);
    check_eq("a_data_errs", data_errs, 0);
    check_eq("a_idle_wdata", idle_errs, 0);
    check_eq("a_core_start_cnt", cs_cnt, 1);
    check_eq("a_start_after_783", wr_at_cs, 784);
    check_eq("a_busy_run", busy, 1'b1);
    check_eq("a_frame_err", frame_err, 1'b0);

    // Byte during RUN is discarded
    core_addr = 10'h155;
    clear_mon();
    pulse_rx(8'hFF);
    check_eq("run_rx_we", ram_we, 1'b0);
    wait_cycles(10);
    check_eq("run_rx_err", frame_err, 1'b1);
    check_eq("run_rx_wr_cnt", wr_cnt, 0);
    check_eq("run_rx_cs_cnt", cs_cnt, 0);
    check_eq("run_core_addr", ram_addr, 10'h155);
    check_eq("run_busy", busy, 1'b1);

    // Completion, transmit and handshake
    tx_rdy     = 1'b0;
    core_digit = 4'd7;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    check_eq("tx_start_hi", tx_start, 1'b1);
    check_eq("tx_data", tx_data, 8'h07);
    check_eq("led", led, 8'h07);
    wait_cycles(20);
    check_eq("tx_wait_busy", busy, 1'b1);
    check_eq("tx_start_cnt", ts_cnt, 1);
    tx_rdy = 1'b1;
    tick();
    check_eq("tx_done_busy", busy, 1'b0);

    // core_done while idle has no effect
    core_digit = 4'd3;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    wait_cycles(2);
    check_eq("stray_done_led", led, 8'h07);
    check_eq("stray_done_busy", busy, 1'b0);
    check_eq("stray_done_tx", ts_cnt, 1);

    // Partial frame timeout
    pulse_rx(8'h3C);
    check_eq("c_first_clears_err", frame_err, 1'b0);
    wait_cycles(9);
    send_bytes(8'h3C, 49, 9);
    pulse_rx(8'h3C);
    wait_cycles(79);
    check_eq("c_no_timeout_yet", frame_err, 1'b0);
    wait_cycles(40);
    check_eq("c_timeout_err", frame_err, 1'b1);
    cur_byte = 8'h81;
    clear_mon();
    pulse_rx(8'h81);
    wait_cycles(10);
    check_eq("c_new_frame_clr", frame_err, 1'b0);
    check_eq("c_new_wr_cnt", wr_cnt, 8);
    check_eq("c_new_addr_errs", addr_errs, 0);
    check_eq("c_new_data_errs", data_errs, 0);
    wait_cycles(130);
    check_eq("c_timeout2_err", frame_err, 1'b1);

    // Reset in the middle of byte 60
    send_bytes(8'h5A, 59, 12);
    pulse_rx(8'h5A);
    tick();
    pulse_rx(8'h5A);
    check_eq("d_pre_rst_err", frame_err, 1'b1);
    #3;
    rst_n = 1'b0;
    #2;
    check_eq("d_rst_we", ram_we, 1'b0);
    check_eq("d_rst_busy", busy, 1'b0);
    check_eq("d_rst_err", frame_err, 1'b0);
    check_eq("d_rst_led", led, 8'h00);
    check_eq("d_rst_tx_data", tx_data, 8'h00);
    check_eq("d_rst_ram_addr", ram_addr, 10'h155);
    tick();
    rst_n = 1'b1;
    wait_cycles(3);
    cur_byte = 8'h5A;
    clear_mon();
    wait_cycles(20);
    check_eq("d_no_spurious_cs", cs_cnt, 0);
    send_bytes(8'h5A, 98, 12);
    check_eq("d_wr_cnt", wr_cnt, 784);
    check_eq("d_addr_errs", addr_errs, 0);
    check_eq("d_data_errs", data_errs, 0);
    check_eq("d_cs_cnt", cs_cnt, 1);
    check_eq("d_start_after_783", wr_at_cs, 784);
    check_eq("d_ts_cnt", ts_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
